// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the control unit and the datapath: state encoding,
// packed control word, opcode values and mux select encodings.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_ADD, S_AND, S_NOT,
    S_BR0, S_BR1, S_JMP, S_JSR0, S_JSR1,
    S_LDR0, S_LDR1, S_LDR2, S_LDR3,
    S_STR0, S_STR1, S_STR2,
    S_PAUSE1, S_PAUSE2
  } state_t;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_pc;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_ben;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;   // 0: PC, 1: BaseR (SR1 out)
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       drmux;      // 0: IR[11:9], 1: R7
    logic       sr1mux;     // 0: IR[11:9], 1: IR[8:6]
    logic       sr2mux;     // 1: datapath may pick imm5 when IR[5]=1
  } ctrl_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2MUX_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2MUX_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2MUX_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2MUX_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

endpackage

// File: rtl/mem_wait_timer.sv
// SRAM access window timer: 4-bit down-counter, preloaded with MEM_WAIT-1
// outside memory states and counted down to zero inside them. No wrap.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT = 2   // legal range 1..15
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);
  localparam logic [3:0] LOAD_VAL = 4'(MEM_WAIT - 1);

  logic [3:0] count;

  // Reload has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= LOAD_VAL;
    else if (dec && count != 4'd0)
      count <= count - 4'd1;
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/cpu_control_fsm.sv
// Control unit: Moore FSM sequencing fetch/decode/execute for the 16-bit datapath.
// Optional build macro CPU_SINGLE_STEP_EN: every instruction ends in the pause
// states (LEDs untouched), so each continue press runs one instruction.
//
// state     | meaning
// S_HALTED  | idle, waiting for run_i
// S_FETCH1  | MAR<-PC, PC<-PC+1
// S_FETCH2  | SRAM read window, MDR<-M on last cycle
// S_FETCH3  | IR<-MDR
// S_DECODE  | ld_ben, dispatch on opcode
// S_ADD/AND/NOT | ALU result to DR, set CC
// S_BR0/BR1 | branch test / PC<-PC+off9
// S_JMP     | PC<-BaseR
// S_JSR0/1  | R7<-PC / PC<-PC+off11
// S_LDR0..3 | MAR<-BaseR+off6, read window, MDR<-M, DR<-MDR
// S_STR0..2 | MAR<-BaseR+off6, MDR<-SR, write window
// S_PAUSE1  | show IR[11:0] on LEDs, wait for continue press
// S_PAUSE2  | wait for continue release
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_i,
  input  logic        continue_i,
  input  logic [15:0] ir_i,
  input  logic        ben_i,
  output ctrl_t       ctrl_o,
  output logic        mem_ena_o,
  output logic        mem_wr_o,
  output logic        halted_o
);
  state_t      state, state_next, end_next;
  logic        in_mem, timer_done, step_flag;
  logic [11:0] unused_ir;

  assign unused_ir = ir_i[11:0];
  assign in_mem    = (state == S_FETCH2) || (state == S_LDR1) || (state == S_STR2);

  mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (!in_mem),
    .dec   (in_mem),
    .done  (timer_done)
  );

`ifdef CPU_SINGLE_STEP_EN
  assign end_next = run_i ? S_PAUSE1 : S_HALTED;

  // Marks a pause entered at the end of an ordinary instruction (LEDs not loaded).
  always_ff @(posedge clk) begin
    if (reset)
      step_flag <= 1'b0;
    else if (state_next == S_PAUSE1 && state != S_PAUSE1)
      step_flag <= (state != S_DECODE);
  end
`else
  assign end_next  = run_i ? S_FETCH1 : S_HALTED;
  assign step_flag = 1'b0;
`endif

  // State register; reset wins in every state.
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_HALTED;
    else
      state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      S_HALTED: if (run_i) state_next = S_FETCH1;
      S_FETCH1: state_next = S_FETCH2;
      S_FETCH2: if (timer_done) state_next = S_FETCH3;
      S_FETCH3: state_next = S_DECODE;
      S_DECODE: begin
        case (ir_i[15:12])
          OP_ADD:   state_next = S_ADD;
          OP_AND:   state_next = S_AND;
          OP_NOT:   state_next = S_NOT;
          OP_BR:    state_next = S_BR0;
          OP_JMP:   state_next = S_JMP;
          OP_JSR:   state_next = S_JSR0;
          OP_LDR:   state_next = S_LDR0;
          OP_STR:   state_next = S_STR0;
          OP_PAUSE: state_next = S_PAUSE1;
          default:  state_next = S_FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT, S_JMP, S_BR1, S_JSR1, S_LDR3: state_next = end_next;
      S_BR0:    state_next = ben_i ? S_BR1 : end_next;
      S_JSR0:   state_next = S_JSR1;
      S_LDR0:   state_next = S_LDR1;
      S_LDR1:   if (timer_done) state_next = S_LDR2;
      S_LDR2:   state_next = S_LDR3;
      S_STR0:   state_next = S_STR1;
      S_STR1:   state_next = S_STR2;
      S_STR2:   if (timer_done) state_next = end_next;
      S_PAUSE1: if (continue_i) state_next = S_PAUSE2;
      S_PAUSE2: if (!continue_i) state_next = S_FETCH1;
      default:  state_next = S_HALTED;
    endcase
  end

  // Moore output decode from the state register (timer count is state too).
  always_comb begin
    ctrl_o    = '0;
    mem_ena_o = 1'b0;
    mem_wr_o  = 1'b0;
    halted_o  = 1'b0;
    unique case (state)
      S_HALTED: halted_o = 1'b1;
      S_FETCH1: begin
        ctrl_o.ld_mar  = 1'b1;
        ctrl_o.gate_pc = 1'b1;
        ctrl_o.ld_pc   = 1'b1;
        ctrl_o.pcmux   = PCMUX_INC;
      end
      S_FETCH2: begin
        mem_ena_o     = 1'b1;
        ctrl_o.ld_mdr = timer_done;
      end
      S_FETCH3: begin
        ctrl_o.gate_mdr = 1'b1;
        ctrl_o.ld_ir    = 1'b1;
      end
      S_DECODE: ctrl_o.ld_ben = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        ctrl_o.ld_reg   = 1'b1;
        ctrl_o.ld_cc    = 1'b1;
        ctrl_o.gate_alu = 1'b1;
        ctrl_o.sr1mux   = 1'b1;
        ctrl_o.sr2mux   = (state != S_NOT);
        ctrl_o.aluk     = (state == S_ADD) ? ALUK_ADD :
                          (state == S_AND) ? ALUK_AND : ALUK_NOT;
      end
      S_BR1: begin
        ctrl_o.ld_pc    = 1'b1;
        ctrl_o.pcmux    = PCMUX_ADDER;
        ctrl_o.addr2mux = ADDR2MUX_OFF9;
      end
      S_JMP: begin
        ctrl_o.ld_pc    = 1'b1;
        ctrl_o.pcmux    = PCMUX_ADDER;
        ctrl_o.addr1mux = 1'b1;
        ctrl_o.addr2mux = ADDR2MUX_ZERO;
        ctrl_o.sr1mux   = 1'b1;
      end
      S_JSR0: begin
        ctrl_o.ld_reg  = 1'b1;
        ctrl_o.gate_pc = 1'b1;
        ctrl_o.drmux   = 1'b1;
      end
      S_JSR1: begin
        ctrl_o.ld_pc    = 1'b1;
        ctrl_o.pcmux    = PCMUX_ADDER;
        ctrl_o.addr2mux = ADDR2MUX_OFF11;
      end
      S_LDR0, S_STR0: begin
        ctrl_o.ld_mar      = 1'b1;
        ctrl_o.gate_marmux = 1'b1;
        ctrl_o.addr1mux    = 1'b1;
        ctrl_o.addr2mux    = ADDR2MUX_OFF6;
        ctrl_o.sr1mux      = 1'b1;
      end
      S_LDR1: mem_ena_o = 1'b1;
      // MDR captures the read data one cycle after the access window closes.
      S_LDR2: ctrl_o.ld_mdr = 1'b1;
      S_LDR3: begin
        ctrl_o.gate_mdr = 1'b1;
        ctrl_o.ld_reg   = 1'b1;
        ctrl_o.ld_cc    = 1'b1;
      end
      S_STR1: begin
        ctrl_o.ld_mdr   = 1'b1;
        ctrl_o.gate_alu = 1'b1;
        ctrl_o.aluk     = ALUK_PASS;
      end
      S_STR2: begin
        mem_ena_o = 1'b1;
        mem_wr_o  = 1'b1;
      end
      S_PAUSE1: ctrl_o.ld_led = !step_flag;
      default: ;
    endcase
  end

endmodule
